// File: rtl/rf_write_arbiter_pkg.sv
// ISA widths and the register write transport shared by writeback, debug and the
// register file. The arbiter's FSM state type also lives here.
package rv32_isa;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
endpackage

package reg_transport;
    import rv32_isa::*;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } reg_transport_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DBG    = 2'd1,
        YIELD  = 2'd2
    } rf_arb_state_t;
endpackage

// File: rtl/rf_write_arbiter_rr.sv
// Combinational round-robin picker: the first set request at or after ptr
// (wrapping) receives a one-hot grant. Shared with other write/issue arbiters.
module rr_arbiter #(
    parameter int NReq = 3
) (
    input  logic [NReq-1:0]         req,
    input  logic [$clog2(NReq)-1:0] ptr,
    output logic [NReq-1:0]         gnt
);
    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NReq; i++) begin
            idx = (int'(ptr) + i) % NReq;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Register file write-port arbiter: round-robin among writeback sources, debug
// preferred but forced to yield one slot after MaxDbgBurst back-to-back grants.
module rf_write_arbiter
    import reg_transport::*;
#(
    parameter int NReq        = 3,
    parameter int MaxDbgBurst = 4
) (
    input  logic                        iClk,
    input  logic                        nRst,
    input  logic [NReq-1:0]             iValid,
    input  reg_transport_t [NReq-1:0]   iRd,
    output logic [NReq-1:0]             oReady,
    input  logic                        iDbgValid,
    input  reg_transport_t              iDbgRd,
    output logic                        oDbgReady,
    output logic                        oWriteEn,
    output reg_transport_t              oRd,
    output logic                        oDbgYield
);
    localparam int PtrW = $clog2(NReq);
    localparam int CntW = $clog2(MaxDbgBurst + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxDbgBurst);

    rf_arb_state_t   state, state_n;
    logic [CntW-1:0] dbg_cnt, cnt_n;
    logic [PtrW-1:0] rr_ptr, ptr_n;
    logic [NReq-1:0] rr_gnt;
    logic            dbg_gnt, rr_en, xfer;
    reg_transport_t  sel;

    rr_arbiter #(.NReq(NReq)) u_rr (
        .req (iValid),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    always_comb begin
        state_n = state;
        cnt_n   = dbg_cnt;
        dbg_gnt = 1'b0;
        rr_en   = 1'b0;
        unique case (state)
            DBG: begin
                if (!iDbgValid) begin
                    rr_en   = 1'b1;
                    cnt_n   = '0;
                    state_n = NORMAL;
                end else if (dbg_cnt < CntMax) begin
                    dbg_gnt = 1'b1;
                    cnt_n   = dbg_cnt + CntW'(1);
                end else if (|iValid) begin
                    rr_en   = 1'b1;
                    state_n = YIELD;
                end else begin
                    // nobody else is waiting, so debug keeps the port at saturation
                    dbg_gnt = 1'b1;
                end
            end
            default: begin
                // NORMAL and YIELD share behaviour; YIELD only lasts one cycle
                if (iDbgValid) begin
                    dbg_gnt = 1'b1;
                    cnt_n   = CntW'(1);
                    state_n = DBG;
                end else begin
                    rr_en   = 1'b1;
                    cnt_n   = '0;
                    state_n = NORMAL;
                end
            end
        endcase
    end

    // Readies must drop the instant reset asserts, not just at the next edge.
    assign oReady    = (rr_en && nRst) ? rr_gnt : '0;
    assign oDbgReady = dbg_gnt && nRst;
    assign oDbgYield = (state == YIELD);

    always_comb begin
        sel   = iDbgRd;
        ptr_n = rr_ptr;
        xfer  = oDbgReady;
        for (int k = 0; k < NReq; k++) begin
            if (oReady[k]) begin
                sel   = iRd[k];
                ptr_n = PtrW'((k + 1) % NReq);
                xfer  = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state    <= NORMAL;
            dbg_cnt  <= '0;
            rr_ptr   <= '0;
            oWriteEn <= 1'b0;
            oRd      <= '0;
        end else begin
            state   <= state_n;
            dbg_cnt <= cnt_n;
            rr_ptr  <= ptr_n;
            // x0 is accepted but never reaches the register file
            oWriteEn <= xfer && (sel.addr != '0);
            if (xfer && (sel.addr != '0))
                oRd <= sel;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand sequences for reset and
// debug bursts, then randomized traffic against a streak-based reference model.
module tb_rf_write_arbiter;
    import reg_transport::*;

    localparam int N  = 3;
    localparam int MB = 4;

    logic                   iClk = 1'b0;
    logic                   nRst;
    logic [N-1:0]           iValid;
    reg_transport_t [N-1:0] iRd;
    logic [N-1:0]           oReady;
    logic                   iDbgValid;
    reg_transport_t         iDbgRd;
    logic                   oDbgReady;
    logic                   oWriteEn;
    reg_transport_t         oRd;
    logic                   oDbgYield;

    int n_chk  = 0;
    int n_fail = 0;

    rf_write_arbiter #(.NReq(N), .MaxDbgBurst(MB)) dut (
        .iClk      (iClk),
        .nRst      (nRst),
        .iValid    (iValid),
        .iRd       (iRd),
        .oReady    (oReady),
        .iDbgValid (iDbgValid),
        .iDbgRd    (iDbgRd),
        .oDbgReady (oDbgReady),
        .oWriteEn  (oWriteEn),
        .oRd       (oRd),
        .oDbgYield (oDbgYield)
    );

    always #5 iClk = ~iClk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [2:0] v;
        logic       dv;
        logic       x0;
        logic [2:0] rdy;
        logic       drdy;
        logic       yld;
        logic       we;
        logic [4:0] addr;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic default_rd();
        for (int k = 0; k < N; k++) iRd[k] = '{addr: 5'(5 + k), data: 32'(32'h100 + k)};
        iDbgRd = '{addr: 5'd9, data: 32'hD0};
    endtask

    task automatic check_grants(input string tag, input logic [2:0] rdy, input logic drdy, input logic yld);
        check({tag, "_ready"}, 64'(oReady), 64'(rdy));
        check({tag, "_dbg_ready"}, 64'(oDbgReady), 64'(drdy));
        check({tag, "_yield"}, 64'(oDbgYield), 64'(yld));
    endtask

    // Reference model: debug wins unless it already holds MB consecutive grants
    // and a writeback source is waiting; yield is visible the cycle after that.
    int             m_ptr, m_streak;
    bit             m_prev_forced, m_we;
    reg_transport_t m_rd;
    logic [N-1:0]   pend;
    bit             dpend;

    task automatic model_step(input int cyc);
        bit             any_v, forced, dg, found;
        int             k, gk;
        logic [N-1:0]   exp_rdy;
        reg_transport_t s;
        any_v   = |iValid;
        forced  = iDbgValid && (m_streak >= MB) && any_v;
        dg      = iDbgValid && !forced;
        exp_rdy = '0;
        found   = 0;
        gk      = 0;
        if (!dg) begin
            for (int j = 0; j < N; j++) begin
                k = (m_ptr + j) % N;
                if (!found && iValid[k]) begin
                    found = 1; gk = k; exp_rdy[k] = 1'b1;
                end
            end
        end
        check($sformatf("rand%0d_ready", cyc), 64'(oReady), 64'(exp_rdy));
        check($sformatf("rand%0d_dbg_ready", cyc), 64'(oDbgReady), 64'(dg));
        check($sformatf("rand%0d_yield", cyc), 64'(oDbgYield), 64'(m_prev_forced));
        check($sformatf("rand%0d_we", cyc), 64'(oWriteEn), 64'(m_we));
        check($sformatf("rand%0d_rd", cyc), 64'(oRd), 64'(m_rd));
        m_prev_forced = forced;
        m_we = 0;
        if (dg) begin
            m_streak = (m_streak >= MB) ? MB : m_streak + 1;
            s = iDbgRd;
            dpend = 0;
            if (s.addr != 0) begin m_we = 1; m_rd = s; end
        end else begin
            m_streak = 0;
            if (found) begin
                s = iRd[gk];
                m_ptr = (gk + 1) % N;
                pend[gk] = 1'b0;
                if (s.addr != 0) begin m_we = 1; m_rd = s; end
            end
        end
    endtask

    initial begin
        tbl[0]  = '{3'b111, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[1]  = '{3'b111, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 5'd5};
        tbl[2]  = '{3'b111, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 5'd6};
        tbl[3]  = '{3'b111, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 5'd7};
        tbl[4]  = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5};
        tbl[5]  = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd5};
        tbl[6]  = '{3'b100, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd5};
        tbl[7]  = '{3'b100, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd9};
        tbl[8]  = '{3'b100, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd9};
        tbl[9]  = '{3'b100, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd9};
        tbl[10] = '{3'b100, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 5'd9};
        tbl[11] = '{3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 5'd7};
        tbl[12] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd9};
        tbl[13] = '{3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 5'd9};
        tbl[14] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd9};

        // Reset with every source requesting: nothing may be granted.
        nRst = 1'b0; iValid = '1; iDbgValid = 1'b1;
        default_rd();
        #3;
        check_grants("reset", 3'b000, 1'b0, 1'b0);
        check("reset_we", 64'(oWriteEn), 64'(0));
        check("reset_rd", 64'(oRd), 64'(0));
        @(posedge iClk); #1;
        check("reset_hold_we", 64'(oWriteEn), 64'(0));
        check("reset_hold_ready", 64'(oReady), 64'(0));
        iValid = '0; iDbgValid = 1'b0;
        @(negedge iClk); nRst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(posedge iClk); #1;
            default_rd();
            if (tbl[i].x0) iRd[1] = '{addr: 5'd0, data: 32'hDEADBEEF};
            iValid = tbl[i].v; iDbgValid = tbl[i].dv;
            @(negedge iClk);
            check_grants($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].drdy, tbl[i].yld);
            check($sformatf("vec%0d_we", i), 64'(oWriteEn), 64'(tbl[i].we));
            check($sformatf("vec%0d_addr", i), 64'(oRd.addr), 64'(tbl[i].addr));
        end
        check("x0_data_not_written", 64'(oRd.data), 64'(32'hD0));

        // Debug alone streams without ever yielding.
        default_rd();
        for (int i = 0; i < 10; i++) begin
            @(posedge iClk); #1;
            iValid = '0; iDbgValid = 1'b1;
            @(negedge iClk);
            check_grants($sformatf("dbg_alone%0d", i), 3'b000, 1'b1, 1'b0);
        end
        @(posedge iClk); #1;
        iDbgValid = 1'b0;
        @(negedge iClk);
        check("dbg_alone_last_we", 64'(oWriteEn), 64'(1));
        check("dbg_alone_last_addr", 64'(oRd.addr), 64'(9));

        // Reset after the second debug grant, then a full fresh burst of MB.
        for (int i = 0; i < 2; i++) begin
            @(posedge iClk); #1;
            iValid = 3'b100; iDbgValid = 1'b1;
            @(negedge iClk);
            check_grants($sformatf("midrst_pre%0d", i), 3'b000, 1'b1, 1'b0);
        end
        @(posedge iClk); #1;
        check("midrst_we_before", 64'(oWriteEn), 64'(1));
        nRst = 1'b0;
        #1;
        check("midrst_we_drop", 64'(oWriteEn), 64'(0));
        check("midrst_rd_clear", 64'(oRd), 64'(0));
        check_grants("midrst_in_reset", 3'b000, 1'b0, 1'b0);
        @(negedge iClk); nRst = 1'b1;
        #1;
        check_grants("midrst_post0", 3'b000, 1'b1, 1'b0);
        for (int j = 1; j < 6; j++) begin
            @(negedge iClk);
            if (j < 4)       check_grants($sformatf("midrst_post%0d", j), 3'b000, 1'b1, 1'b0);
            else if (j == 4) check_grants($sformatf("midrst_post%0d", j), 3'b100, 1'b0, 1'b0);
            else             check_grants($sformatf("midrst_post%0d", j), 3'b000, 1'b1, 1'b1);
        end
        @(posedge iClk); #1;
        iValid = '0; iDbgValid = 1'b0;

        // Randomized traffic against the reference model.
        @(negedge iClk); nRst = 1'b0;
        @(negedge iClk); nRst = 1'b1;
        m_ptr = 0; m_streak = 0; m_prev_forced = 0; m_we = 0; m_rd = '0;
        pend = '0; dpend = 0;
        for (int c = 0; c < 500; c++) begin
            @(posedge iClk); #1;
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && ($urandom % 3 == 0)) begin
                    pend[k] = 1'b1;
                    iRd[k].addr = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
                    iRd[k].data = $urandom;
                end
            end
            if (!dpend && ($urandom % 2 == 0)) begin
                dpend = 1;
                iDbgRd.addr = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
                iDbgRd.data = $urandom;
            end
            iValid = pend; iDbgValid = dpend;
            @(negedge iClk);
            model_step(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
